breath_mode_ctrl: RTL and testbench

Upstream control stage for the breathing-LED path. Debounces a raw active-low push button and runs a small press-classification FSM. Cycles a 2-bit brightness mode on short presses and forces OFF on a long press. Emits the enable, force-on and timebase tick pulses that the downstream PWM breathing stage consumes in place of a free-running microsecond divider.

---
 rtl/breath_mode_ctrl_if.sv | 23 ++
 rtl/breath_mode_ctrl.sv | 157 +++++++++++++++
 tb/tb_breath_mode_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/breath_mode_ctrl_if.sv
// Bundles the button input and the breathing-stage control outputs of breath_mode_ctrl.
// Latency: none, wiring only.
// Backpressure: none; all signals are levels or single-cycle pulses.
// Ports: key_n (raw active-low button), mode[1:0], breath_en, led_force, tick, press_pulse.
// master = the controller (drives the outputs), slave = the consumer side (drives key_n).
interface breath_mode_ctrl_if;
  logic       key_n;
  logic [1:0] mode;
  logic       breath_en;
  logic       led_force;
  logic       tick;
  logic       press_pulse;

  modport master (
    input  key_n,
    output mode, breath_en, led_force, tick, press_pulse
  );

  modport slave (
    output key_n,
    input  mode, breath_en, led_force, tick, press_pulse
  );
endinterface

// File: rtl/breath_mode_ctrl.sv
// Debounces an active-low button, classifies short/long presses, cycles a 2-bit LED mode and emits breathing timebase ticks.
// Latency: key_n -> key_db 2+DEBOUNCE_CYCLES edges; key_db rise -> mode/press_pulse 1 edge; mode -> breath_en/led_force 1 edge.
// Backpressure: none; outputs are levels and single-cycle pulses that are never stalled.
// Ports: clk, rst (sync, active-high), bus (master): key_n in; mode, breath_en, led_force, tick, press_pulse out.
module breath_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int TICK_DIV_SLOW     = 100,
  parameter int TICK_DIV_FAST     = 50
) (
  input  logic                clk,
  input  logic                rst,
  breath_mode_ctrl_if.master  bus
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int HW   = $clog2(LONG_PRESS_CYCLES);
  localparam int TMAX = (TICK_DIV_SLOW > TICK_DIV_FAST) ? TICK_DIV_SLOW : TICK_DIV_FAST;
  localparam int TW   = $clog2(TMAX);

  localparam logic [DW-1:0] DCNT_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [TW-1:0] TSLOW_MAX = TW'(TICK_DIV_SLOW - 1);
  localparam logic [TW-1:0] TFAST_MAX = TW'(TICK_DIV_FAST - 1);

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_SLOW = 2'd1;
  localparam logic [1:0] MODE_FAST = 2'd2;
  localparam logic [1:0] MODE_ON   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_LONG} state_t;

  logic          key_sync1;
  logic          key_s;
  logic          key_db;
  logic          key_db_d;
  logic [DW-1:0] dcnt;
  logic          press_evt;
  logic          release_evt;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [1:0]    mode_r, mode_nxt;
  logic          pulse_nxt;
  logic          press_pulse_r;
  logic          breath_en_r;
  logic          led_force_r;

  logic [TW-1:0] tcnt;
  logic          tick_r;

  // Two-flop synchronizer plus debounce: key_db only follows key_s after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sync1 <= 1'b1;
      key_s     <= 1'b1;
      key_db    <= 1'b1;
      key_db_d  <= 1'b1;
      dcnt      <= '0;
    end else begin
      key_sync1 <= bus.key_n;
      key_s     <= key_sync1;
      key_db_d  <= key_db;
      if (key_s == key_db) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_MAX) begin
        key_db <= key_s;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign press_evt   =  key_db_d & ~key_db;
  assign release_evt = ~key_db_d &  key_db;

  // Press classification. Release is tested before the long-press limit so a
  // release landing on the limit cycle still counts as a short press.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    mode_nxt  = mode_r;
    pulse_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_evt) begin
          state_nxt = ST_PRESSED;
          hcnt_nxt  = '0;
        end
      end
      ST_PRESSED: begin
        if (release_evt) begin
          mode_nxt  = mode_r + 2'd1;
          pulse_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else if (hcnt == HCNT_MAX) begin
          mode_nxt  = MODE_OFF;
          state_nxt = ST_LONG;
        end else begin
          hcnt_nxt  = hcnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (release_evt) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      hcnt          <= '0;
      mode_r        <= MODE_OFF;
      press_pulse_r <= 1'b0;
      breath_en_r   <= 1'b0;
      led_force_r   <= 1'b0;
    end else begin
      state         <= state_nxt;
      hcnt          <= hcnt_nxt;
      mode_r        <= mode_nxt;
      press_pulse_r <= pulse_nxt;
      breath_en_r   <= (mode_r == MODE_SLOW) || (mode_r == MODE_FAST);
      led_force_r   <= (mode_r == MODE_ON);
    end
  end

  // Timebase: restarts from 0 whenever the mode is about to change, so the
  // first tick in a new mode lands exactly one full period after the change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt   <= '0;
      tick_r <= 1'b0;
    end else if ((mode_nxt != mode_r) || (mode_r == MODE_OFF) || (mode_r == MODE_ON)) begin
      tcnt   <= '0;
      tick_r <= 1'b0;
    end else if (((mode_r == MODE_SLOW) && (tcnt == TSLOW_MAX)) ||
                 ((mode_r == MODE_FAST) && (tcnt == TFAST_MAX))) begin
      tcnt   <= '0;
      tick_r <= 1'b1;
    end else begin
      tcnt   <= tcnt + 1'b1;
      tick_r <= 1'b0;
    end
  end

  assign bus.mode        = mode_r;
  assign bus.breath_en   = breath_en_r;
  assign bus.led_force   = led_force_r;
  assign bus.tick        = tick_r;
  assign bus.press_pulse = press_pulse_r;

endmodule

// File: tb/tb_breath_mode_ctrl.sv
// Bench for breath_mode_ctrl: directed scenarios plus random presses, glitches and resets.
// Outputs are compared every cycle against an edge-indexed behavioural model with history arrays.
// Hand-computed literal expectations pin latencies, mode sequence, tick counts and pulse counts.
module tb_breath_mode_ctrl;

  localparam int DEB  = 8;
  localparam int LONG = 40;
  localparam int SLOW = 5;
  localparam int FAST = 3;
  localparam int MAXE = 32768;

  logic clk = 1'b0;
  logic rst;

  breath_mode_ctrl_if bus();

  breath_mode_ctrl #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .TICK_DIV_SLOW     (SLOW),
    .TICK_DIV_FAST     (FAST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, indexed by clock edge number.
  bit raw_h [MAXE];   // key_n as seen by the first sync flop (1 under reset)
  bit ks_h  [MAXE];   // synchronized key after each edge
  bit db_h  [MAXE];   // debounced key after each edge
  bit rst_h [MAXE];
  int e = -1;
  int ph = 0;         // 0 idle, 1 held, 2 long-press consumed
  int pstart = 0;
  int m_mode = 0;
  int m_changed = 0;
  bit m_valid = 1'b0;
  int x_mode = 0;
  bit x_pulse, x_tick, x_ben, x_lf;

  task automatic model_step();
    bit db1, db2, flip, prs, rel;
    int old_mode, div;
    e = e + 1;
    if (e >= MAXE) begin
      $display("FAIL model_depth: edge %0d exceeds history %0d", e, MAXE);
      $fatal(1);
    end
    rst_h[e] = rst;
    raw_h[e] = rst ? 1'b1 : bus.key_n;
    if (rst) begin
      ks_h[e] = 1'b1;
      db_h[e] = 1'b1;
      ph = 0;
      m_mode = 0;
      m_changed = e;
      x_pulse = 1'b0;
      x_tick = 1'b0;
      x_ben = 1'b0;
      x_lf = 1'b0;
    end else begin
      ks_h[e] = (e > 0) ? raw_h[e-1] : 1'b1;
      db1 = (e > 0) ? db_h[e-1] : 1'b1;
      // accept a new level once the last DEB synchronized samples all disagree
      flip = 1'b1;
      for (int j = 1; j <= DEB; j++) begin
        if (e - j < 0) flip = 1'b0;
        else if (ks_h[e-j] == db1) flip = 1'b0;
      end
      db_h[e] = flip ? ~db1 : db1;
      db2 = (e < 2 || rst_h[e-1]) ? 1'b1 : db_h[e-2];
      prs = db2 && !db1;
      rel = !db2 && db1;
      old_mode = m_mode;
      x_pulse = 1'b0;
      if (ph == 0) begin
        if (prs) begin ph = 1; pstart = e; end
      end else if (ph == 1) begin
        if (rel) begin
          m_mode = (m_mode + 1) % 4;
          x_pulse = 1'b1;
          ph = 0;
        end else if (e - pstart == LONG) begin
          m_mode = 0;
          ph = 2;
        end
      end else begin
        if (rel) ph = 0;
      end
      x_ben = (old_mode == 1) || (old_mode == 2);
      x_lf  = (old_mode == 3);
      if (m_mode != old_mode) m_changed = e;
      div = (m_mode == 1) ? SLOW : (m_mode == 2) ? FAST : 0;
      x_tick = (div > 0) && (m_changed < e) && (((e - m_changed) % div) == 0);
    end
    x_mode = m_mode;
    m_valid = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("mode",        int'(bus.mode),        x_mode);
        check("breath_en",   int'(bus.breath_en),   int'(x_ben));
        check("led_force",   int'(bus.led_force),   int'(x_lf));
        check("tick",        int'(bus.tick),        int'(x_tick));
        check("press_pulse", int'(bus.press_pulse), int'(x_pulse));
        if (bus.press_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
      end
    end
  end

  task automatic press_key(input int hold, input int gap);
    bus.key_n = 1'b0;
    repeat (hold) @(negedge clk);
    bus.key_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic count_ticks(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.tick === 1'b1) n = n + 1;
    end
  endtask

  int exp_modes [4] = '{1, 2, 3, 0};
  int p0, n, k;
  bit found;

  initial begin
    rst = 1'b1;
    bus.key_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mode",        int'(bus.mode), 0);
    check("reset_tick",        int'(bus.tick), 0);
    check("reset_breath_en",   int'(bus.breath_en), 0);
    check("reset_led_force",   int'(bus.led_force), 0);
    check("reset_press_pulse", int'(bus.press_pulse), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    // 7-cycle glitch must be rejected
    p0 = pulse_cnt;
    press_key(7, 30);
    check("glitch_mode", int'(bus.mode), 0);
    check("glitch_pulses", pulse_cnt - p0, 0);

    // short presses step the mode 1,2,3,0
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      press_key(20, 20);
      check("cycle_mode", int'(bus.mode), exp_modes[i]);
      check("cycle_breath_en", int'(bus.breath_en), (exp_modes[i] == 1 || exp_modes[i] == 2) ? 1 : 0);
      check("cycle_led_force", int'(bus.led_force), (exp_modes[i] == 3) ? 1 : 0);
    end
    check("cycle_pulses", pulse_cnt - p0, 4);

    // tick rates: SLOW 50 cycles -> 10 ticks, FAST 30 -> 10, ON 30 -> 0
    press_key(20, 20);
    count_ticks(50, n);
    check("slow_ticks", n, 10);
    press_key(20, 20);
    count_ticks(30, n);
    check("fast_ticks", n, 10);
    press_key(20, 20);
    count_ticks(30, n);
    check("on_ticks", n, 0);

    // back to FAST, then long press: mode 0 after 2+DEB+1+LONG = 51 cycles
    press_key(20, 20);
    press_key(20, 20);
    press_key(20, 20);
    check("pre_long_mode", int'(bus.mode), 2);
    p0 = pulse_cnt;
    bus.key_n = 1'b0;
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge clk);
      if (bus.mode == 2'd0) begin
        found = 1'b1;
        k = i;
      end
    end
    check("long_press_latency", k, 51);
    if (k < 60) repeat (60 - k) @(negedge clk);
    bus.key_n = 1'b1;
    repeat (30) @(negedge clk);
    check("long_release_mode", int'(bus.mode), 0);
    check("long_release_pulses", pulse_cnt - p0, 0);

    // reset mid-press in FAST; held key is re-debounced then counts as short
    press_key(20, 20);
    press_key(20, 20);
    check("pre_rst_mode", int'(bus.mode), 2);
    bus.key_n = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midpress_rst_mode", int'(bus.mode), 0);
    p0 = pulse_cnt;
    repeat (30) @(negedge clk);
    bus.key_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_mode", int'(bus.mode), 1);
    check("post_rst_pulses", pulse_cnt - p0, 1);

    // random presses, glitches, long holds and occasional resets
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.key_n = 1'b0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
      press_key($urandom_range(1, 70), $urandom_range(1, 40));
    end
    bus.key_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
